// File: rtl/bus_tx_fifo.sv
// Agent-to-bus transmit FIFO: filters self-addressed packets, presents the head packet
// to the bus arbiter, and keeps sticky overflow, underflow and self-drop diagnostics.
module bus_tx_fifo #(
  parameter int unsigned pckg_sz    = 16,
  parameter int unsigned fifo_depth = 16,
  parameter logic [7:0]  id         = 8'h00,
  parameter logic [7:0]  broadcast  = {8{1'b1}}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_in,
  input  logic [pckg_sz-1:0]            D_in,
  input  logic                          pop,
  output logic [pckg_sz-1:0]            D_pop,
  output logic                          pndng,
  output logic                          full,
  output logic [$clog2(fifo_depth):0]   count,
  output logic                          overflow,
  output logic                          underflow,
  output logic [7:0]                    ovf_cnt,
  output logic                          self_drop
);

  localparam int unsigned AW = $clog2(fifo_depth);
  localparam int unsigned CW = AW + 1;

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;

  logic [7:0] dest;
  logic       is_self;
  logic       push_elig;
  logic       pop_ok;
  logic       push_ok;
  logic       push_drop;

  always_comb begin
    dest      = D_in[pckg_sz-1 -: 8];
    is_self   = (dest == id) && (dest != broadcast);
    push_elig = push_in && !is_self;
    pop_ok    = pop && (count != '0);
    // A simultaneous pop frees the slot, so a push into a full queue is still accepted.
    push_ok   = push_elig && (!full || pop_ok);
    push_drop = push_elig && full && !pop_ok;
  end

  assign pndng = (count != '0);
  assign full  = (count == CW'(fifo_depth));
  assign D_pop = pndng ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wr_ptr] <= D_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      self_drop <= 1'b0;
      ovf_cnt   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CW'(1);
      end
      if (pop && !pop_ok) begin
        underflow <= 1'b1;
      end
      if (push_in && is_self) begin
        self_drop <= 1'b1;
      end
      if (push_drop) begin
        overflow <= 1'b1;
        if (ovf_cnt != '1) begin
          ovf_cnt <= ovf_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_tx_fifo.sv
// Directed bench for bus_tx_fifo: a queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_bus_tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_in;
  logic [15:0] D_in;
  logic        pop;
  logic [15:0] D_pop, D_pop2;
  logic        pndng, full, overflow, underflow, self_drop;
  logic        pndng2, full2, overflow2, underflow2, self_drop2;
  logic [4:0]  count, count2;
  logic [7:0]  ovf_cnt, ovf_cnt2;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  bus_tx_fifo #(.pckg_sz(16), .fifo_depth(16), .id(8'h02), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .push_in(push_in), .D_in(D_in), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow), .ovf_cnt(ovf_cnt), .self_drop(self_drop)
  );

  // Device whose own ID is the broadcast ID: broadcast packets must still be stored.
  bus_tx_fifo #(.pckg_sz(16), .fifo_depth(16), .id(8'hFF), .broadcast(8'hFF)) dut_bc (
    .clk(clk), .reset(reset), .push_in(push_in), .D_in(D_in), .pop(pop),
    .D_pop(D_pop2), .pndng(pndng2), .full(full2), .count(count2),
    .overflow(overflow2), .underflow(underflow2), .ovf_cnt(ovf_cnt2), .self_drop(self_drop2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted packets plus sticky flags.
  logic [15:0] q[$];
  bit m_ovf, m_udf, m_self;
  int m_ocnt;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_self = 0; m_ocnt = 0;
    end else begin
      bit elig, pok;
      pok  = pop && (q.size() != 0);
      elig = push_in && !(D_in[15:8] == 8'h02);
      if (pop && q.size() == 0) m_udf = 1;
      if (push_in && !elig) m_self = 1;
      if (pok) void'(q.pop_front());
      if (elig) begin
        if (q.size() < 16) q.push_back(D_in);
        else begin
          m_ovf = 1;
          if (m_ocnt < 255) m_ocnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_D_pop", 32'(D_pop), (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("model_count", 32'(count), 32'(q.size()));
      chk("model_pndng", 32'(pndng), 32'(q.size() != 0));
      chk("model_full", 32'(full), 32'(q.size() == 16));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
      chk("model_underflow", 32'(underflow), 32'(m_udf));
      chk("model_self_drop", 32'(self_drop), 32'(m_self));
      chk("model_ovf_cnt", 32'(ovf_cnt), 32'(m_ocnt));
    end
  end

  task automatic cyc(input logic p, input logic [15:0] d, input logic pp);
    push_in = p; D_in = d; pop = pp;
    @(negedge clk);
    push_in = 1'b0; D_in = '0; pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b1, 16'h0123, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push_in = 1'b0; D_in = '0; pop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    started = 1'b1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_D_pop", 32'(D_pop), 32'd0);

    // Three pushes then three pops
    cyc(1, 16'h0511, 0);
    chk("t36_first_D_pop", 32'(D_pop), 32'h0511);
    cyc(1, 16'h0622, 0);
    cyc(1, 16'h0733, 0);
    chk("t36_count3", 32'(count), 32'd3);
    cyc(0, 16'h0, 1);
    chk("t36_pop1", 32'(D_pop), 32'h0622);
    cyc(0, 16'h0, 1);
    chk("t36_pop2", 32'(D_pop), 32'h0733);
    cyc(0, 16'h0, 1);
    chk("t36_pop3", 32'(D_pop), 32'h0000);
    chk("t36_pndng", 32'(pndng), 32'd0);

    // Overfill with 20 packets
    for (int i = 0; i < 20; i++) begin
      cyc(1, 16'h0100 + 16'(i), 0);
      if (i == 15) chk("t37_full16", 32'(full), 32'd1);
    end
    chk("t37_overflow", 32'(overflow), 32'd1);
    chk("t37_ovf_cnt", 32'(ovf_cnt), 32'd4);
    for (int i = 0; i < 16; i++) begin
      chk("t37_order", 32'(D_pop), 32'h0100 + 32'(i));
      cyc(0, 16'h0, 1);
    end
    chk("t37_empty", 32'(count), 32'd0);

    // Push and pop together while full
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 16'h0800 + 16'(i), 0);
    cyc(1, 16'h0AAA, 1);
    chk("t38_count", 32'(count), 32'd16);
    chk("t38_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("t38_order", 32'(D_pop), (i < 15) ? 32'h0801 + 32'(i) : 32'h0AAA);
      cyc(0, 16'h0, 1);
    end

    // Self-addressed packet is discarded, broadcast is kept
    do_reset();
    cyc(1, 16'h0255, 0);
    chk("t39_self_drop", 32'(self_drop), 32'd1);
    chk("t39_bc_dev_keeps_0255", 32'(count2), 32'd1);
    cyc(1, 16'hFF01, 0);
    chk("t39_count", 32'(count), 32'd1);
    chk("t39_D_pop", 32'(D_pop), 32'hFF01);
    chk("t39_bc_dev_count", 32'(count2), 32'd2);
    chk("t39_bc_dev_self_drop", 32'(self_drop2), 32'd0);
    cyc(0, 16'h0, 1);

    // Empty pop, then push with pop while empty
    cyc(0, 16'h0, 1);
    chk("t40_underflow", 32'(underflow), 32'd1);
    chk("t40_D_pop0", 32'(D_pop), 32'h0000);
    cyc(1, 16'h0301, 1);
    chk("t40_count", 32'(count), 32'd1);
    chk("t40_D_pop", 32'(D_pop), 32'h0301);

    // Reset mid-traffic
    for (int i = 0; i < 5; i++) cyc(1, 16'h0900 + 16'(i), 0);
    do_reset();
    chk("t41_count", 32'(count), 32'd0);
    chk("t41_pndng", 32'(pndng), 32'd0);
    chk("t41_D_pop", 32'(D_pop), 32'h0000);
    chk("t41_flags", 32'({overflow, underflow, self_drop}), 32'd0);
    chk("t41_ovf_cnt", 32'(ovf_cnt), 32'd0);
    cyc(1, 16'h0404, 0);
    chk("t41_first", 32'(D_pop), 32'h0404);
    cyc(0, 16'h0, 1);
    cyc(0, 16'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_tx_fifo.md
BUS_TX_FIFO -- requirements
Module: bus_tx_fifo

Interface
REQ-001 Parameter: pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] = destination ID.
REQ-002 Parameter: fifo_depth, 16, entry count; power of two, >= 2.
REQ-003 Parameter: id, 0, this device's bus ID (8 bits).
REQ-004 Parameter: broadcast, {8{1'b1}}, broadcast destination ID.
REQ-005 Port: clk  input  1  single clock; all state on rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: push_in  input  1  agent-side write strobe.
REQ-008 Port: D_in  input  pckg_sz  agent-side write data.
REQ-009 Port: pop  input  1  bus-side read strobe, driven by the bus arbiter.
REQ-010 Port: D_pop  output  pckg_sz  head-of-queue packet presented to the bus.
REQ-011 Port: pndng  output  1  high while the queue holds >= 1 packet.
REQ-012 Port: full  output  1  queue holds fifo_depth packets.
REQ-013 Port: count  output  $clog2(fifo_depth)+1  current occupancy.
REQ-014 Port: overflow  output  1  sticky; set when a write is dropped because the queue is full.
REQ-015 Port: underflow  output  1  sticky; set on pop while empty.
REQ-016 Port: ovf_cnt  output  8  dropped-write counter; saturates at 255.
REQ-017 Port: self_drop  output  1  sticky; set when a self-addressed packet is discarded.

Function
REQ-018 Storage: circular buffer with rd_ptr and wr_ptr of width $clog2(fifo_depth); each pointer wraps from fifo_depth-1 to 0.
REQ-019 Accepted write: push_in=1, not full, destination != id → store D_in at wr_ptr, advance wr_ptr.
REQ-020 Self-addressed: push_in=1, destination == id, destination != broadcast → packet not stored, self_drop set, count unchanged.
REQ-021 Broadcast destination: always eligible for storage, including when id equals broadcast.
REQ-022 Accepted pop: pop=1 and count>0 → advance rd_ptr.
REQ-023 Empty pop: pop=1 and count==0 → no pointer change, underflow set.
REQ-024 Simultaneous accepted push and pop: both performed, count unchanged; when full, the pop frees the slot and the push is accepted (no overflow).
REQ-025 Push while full without pop: write dropped, overflow set, ovf_cnt incremented unless already 255.
REQ-026 Push and pop while empty: push stored, pop ignored, underflow set, count becomes 1.
REQ-027 count: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither; range 0..fifo_depth.
REQ-028 pndng = (count != 0); full = (count == fifo_depth); both derived combinationally from count.
REQ-029 D_pop = mem[rd_ptr] combinationally when count != 0, else all zeros.
REQ-030 Latency: a packet pushed at edge N appears on D_pop with pndng=1 immediately after edge N; a pop at edge N exposes the next packet, or zeros, immediately after edge N.
REQ-031 Order: strict FIFO; no reordering, duplication or loss of accepted packets.
REQ-032 Sticky flags and ovf_cnt clear only on reset.

Reset
REQ-033 While reset=1 at a rising edge: rd_ptr=wr_ptr=0, count=0, overflow=underflow=self_drop=0, ovf_cnt=0; push_in and pop ignored.
REQ-034 After that edge: pndng=0, full=0, D_pop=0; stored memory contents need not be cleared.
REQ-035 Reset asserted mid-traffic discards all queued packets; the first cycle after deassertion behaves as empty.

Verification (pckg_sz=16, fifo_depth=16, id=8'h02)
REQ-036 Push 16'h0511, 16'h0622, 16'h0733 on consecutive cycles, then pop three times → D_pop sequence 0511, 0622, 0733, then 0000; pndng falls after the third pop; count returns to 0.
REQ-037 Push 20 packets 16'h0100..16'h0113 with no pops → full=1 after the 16th, overflow=1, ovf_cnt=4; 16 pops return 0100..010F.
REQ-038 With the queue full, assert push (16'h0AAA) and pop in the same cycle → count stays 16, overflow stays 0, 0AAA is the last packet popped.
REQ-039 Push 16'h0255 then 16'hFF01 → only FF01 stored, self_drop=1, count=1, D_pop=FF01.
REQ-040 Pop while empty → underflow=1, count=0, D_pop=0000; then push 16'h0301 with pop high → count=1, D_pop=0301.
REQ-041 Load 5 packets, assert reset for one cycle → count=0, pndng=0, D_pop=0000, all flags 0; the next push of 16'h0404 is the first packet popped.
